// File: rtl/corona_hit_detector.sv
// Per-pixel clamp-versus-corona hit detection feeding the corona position/collision block.
// Two-stage pipeline: box coverage test, then a once-per-frame collision report.
module corona_hit_detector #(
  parameter int NUM_OBJ = 10,
  parameter int OBJ_W   = 32,
  parameter int OBJ_H   = 32
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [10:0]                 pixelX,
  input  logic [10:0]                 pixelY,
  input  logic                        clamp_draw_request,
  input  logic                        other_hit,
  input  logic [0:NUM_OBJ-1][10:0]    topLeftX,
  input  logic [0:NUM_OBJ-1][10:0]    topLeftY,
  input  logic [0:NUM_OBJ-1]          Draw_request,
  output logic                        corona_draw_request,
  output logic                        collision,
  output logic [0:3]                  collision_clamp_corona,
  output logic [3:0]                  hits_in_frame
);

  typedef enum logic {ARMED, REPORTED} state_t;

  localparam logic signed [11:0] ObjW = 12'(OBJ_W);
  localparam logic signed [11:0] ObjH = 12'(OBJ_H);
  localparam logic [3:0]         NonCoronaIdx = 4'd15;

  logic signed [11:0] px;
  logic signed [11:0] py;
  logic [NUM_OBJ-1:0] inside_d;
  logic [NUM_OBJ-1:0] inside_q;
  logic               clamp_q;
  logic               other_q;
  logic               corona_q;

  // Pixels are unsigned screen coordinates; objects may sit partly off-screen (negative).
  assign px = {1'b0, pixelX};
  assign py = {1'b0, pixelY};

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_cover
    logic signed [11:0] x0;
    logic signed [11:0] y0;
    assign x0 = {topLeftX[g][10], topLeftX[g]};
    assign y0 = {topLeftY[g][10], topLeftY[g]};
    assign inside_d[g] = Draw_request[g] && (px >= x0) && (px < x0 + ObjW)
                         && (py >= y0) && (py < y0 + ObjH);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inside_q <= '0;
      clamp_q  <= 1'b0;
      other_q  <= 1'b0;
      corona_q <= 1'b0;
    end else begin
      inside_q <= inside_d;
      clamp_q  <= clamp_draw_request;
      other_q  <= other_hit;
      corona_q <= |inside_d;
    end
  end

  logic [NUM_OBJ-1:0] hitVec;
  logic [3:0]         hitIdx;
  logic               fire;

  // Lowest-numbered corona wins when several overlap the clamp.
  always_comb begin
    hitVec = inside_q & {NUM_OBJ{clamp_q}};
    hitIdx = 4'd0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hitVec[i]) hitIdx = 4'(i);
    end
  end

  state_t     state_q;
  logic       coll_q;
  logic [3:0] idx_q;
  logic [3:0] hits_q;

  assign fire = (state_q == ARMED) && ((|hitVec) || other_q);

  // A frame start always re-arms, even when it lands on the cycle that reports a hit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ARMED;
      coll_q  <= 1'b0;
      idx_q   <= NonCoronaIdx;
      hits_q  <= 4'd0;
    end else begin
      coll_q <= fire;
      if (fire) idx_q <= (|hitVec) ? hitIdx : NonCoronaIdx;
      if (startOfFrame) begin
        state_q <= ARMED;
        hits_q  <= fire ? 4'd1 : 4'd0;
      end else if (fire) begin
        state_q <= REPORTED;
        hits_q  <= (hits_q == 4'd15) ? 4'd15 : hits_q + 4'd1;
      end
    end
  end

  assign corona_draw_request    = corona_q;
  assign collision              = coll_q;
  assign collision_clamp_corona = idx_q;
  assign hits_in_frame          = hits_q;

endmodule

// File: tb/tb_corona_hit_detector.sv
// Directed scenarios plus a randomized run checked against an integer-arithmetic frame model.
module tb_corona_hit_detector;

  localparam int NumObj = 10;

  logic                    clk = 1'b0;
  logic                    resetN;
  logic                    startOfFrame;
  logic [10:0]             pixelX, pixelY;
  logic                    clampDr, otherHit;
  logic [0:NumObj-1][10:0] topLeftX, topLeftY;
  logic [0:NumObj-1]       drawReq;
  logic                    coronaDr, collision;
  logic [0:3]              clampIdx;
  logic [3:0]              hitsInFrame;

  int errors = 0;
  int checks = 0;

  corona_hit_detector #(.NUM_OBJ(NumObj), .OBJ_W(32), .OBJ_H(32)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY),
    .clamp_draw_request(clampDr), .other_hit(otherHit),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .Draw_request(drawReq),
    .corona_draw_request(coronaDr), .collision(collision),
    .collision_clamp_corona(clampIdx), .hits_in_frame(hitsInFrame)
  );

  always #5 clk = ~clk;

  // Reference model: pixels in flight kept as plain masks, one "already reported" flag per frame.
  logic       expCorona = 1'b0;
  logic       expColl   = 1'b0;
  logic [3:0] expIdx    = 4'd15;
  logic [3:0] expHits   = 4'd0;
  int         prevMask  = 0;
  bit         prevClamp = 0;
  bit         prevOther = 0;
  bit         reported  = 0;

  initial begin
    forever begin
      @(posedge clk or negedge resetN);
      if (!resetN) begin
        expCorona = 1'b0; expColl = 1'b0; expIdx = 4'd15; expHits = 4'd0;
        prevMask = 0; prevClamp = 0; prevOther = 0; reported = 0;
      end else begin
        int  curMask;
        int  hitMask;
        int  lowest;
        bit  fire;
        curMask = 0;
        for (int i = 0; i < NumObj; i++) begin
          int x, y, pxI, pyI;
          x = int'($signed(topLeftX[i]));
          y = int'($signed(topLeftY[i]));
          pxI = int'(pixelX);
          pyI = int'(pixelY);
          if (drawReq[i] && pxI >= x && pxI < x + 32 && pyI >= y && pyI < y + 32)
            curMask = curMask | (1 << i);
        end
        hitMask = prevClamp ? prevMask : 0;
        lowest = 15;
        for (int i = NumObj - 1; i >= 0; i--) if (hitMask[i]) lowest = i;
        fire = !reported && (hitMask != 0 || prevOther);
        expColl = fire;
        if (fire) expIdx = 4'(lowest);
        if (startOfFrame) begin
          reported = 0;
          expHits = fire ? 4'd1 : 4'd0;
        end else if (fire) begin
          reported = 1;
          if (expHits != 4'd15) expHits = expHits + 4'd1;
        end
        expCorona = (curMask != 0);
        prevMask = curMask; prevClamp = clampDr; prevOther = otherHit;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearObjs();
    drawReq = '0;
    for (int i = 0; i < NumObj; i++) begin
      topLeftX[i] = 11'd1000;
      topLeftY[i] = 11'd1000;
    end
  endtask

  task automatic placeObj(input int k, input int x, input int y);
    topLeftX[k] = 11'(x);
    topLeftY[k] = 11'(y);
    drawReq[k]  = 1'b1;
  endtask

  // Drive one pixel, then land on the following negedge with outputs settled.
  task automatic applyStimulus(input int x, input int y, input bit clamp, input bit other, input bit sof);
    pixelX = 11'(x); pixelY = 11'(y);
    clampDr = clamp; otherHit = other; startOfFrame = sof;
    @(negedge clk);
  endtask

  task automatic idle(input bit sof = 0);
    applyStimulus(0, 0, 0, 0, sof);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    clearObjs();
    placeObj(0, 0, 0);
    pixelX = 11'd5; pixelY = 11'd5; clampDr = 1'b1; otherHit = 1'b1; startOfFrame = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (coronaDr !== 1'b0) begin errors++; $display("[TB] FAIL reset_corona got=%0d exp=0", coronaDr); end
    checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL reset_collision got=%0d exp=0", collision); end
    checks++; if (clampIdx !== 4'd15) begin errors++; $display("[TB] FAIL reset_index got=%0d exp=15", clampIdx); end
    checks++; if (hitsInFrame !== 4'd0) begin errors++; $display("[TB] FAIL reset_hits got=%0d exp=0", hitsInFrame); end
    clearObjs();
    clampDr = 1'b0; otherHit = 1'b0;
    resetN = 1'b1;
    idle();
  endtask

  task automatic test_basic();
    clearObjs();
    placeObj(0, 70, 200);
    applyStimulus(80, 210, 1, 0, 0);
    checks++; if (coronaDr !== 1'b1) begin errors++; $display("[TB] FAIL basic_corona got=%0d exp=1", coronaDr); end
    checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_collision got=%0d exp=0", collision); end
    idle();
    checks++; if (collision !== 1'b1) begin errors++; $display("[TB] FAIL basic_collision got=%0d exp=1", collision); end
    checks++; if (clampIdx !== 4'd0) begin errors++; $display("[TB] FAIL basic_index got=%0d exp=0", clampIdx); end
    checks++; if (hitsInFrame !== 4'd1) begin errors++; $display("[TB] FAIL basic_hits got=%0d exp=1", hitsInFrame); end
    idle();
    checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL basic_pulse_width got=%0d exp=0", collision); end
    checks++; if (clampIdx !== 4'd0) begin errors++; $display("[TB] FAIL basic_index_hold got=%0d exp=0", clampIdx); end
  endtask

  task automatic test_priority();
    clearObjs();
    placeObj(2, 300, 300);
    placeObj(5, 290, 295);
    idle(1);
    checks++; if (hitsInFrame !== 4'd0) begin errors++; $display("[TB] FAIL prio_sof_clear got=%0d exp=0", hitsInFrame); end
    applyStimulus(310, 310, 1, 0, 0);
    idle();
    checks++; if (collision !== 1'b1) begin errors++; $display("[TB] FAIL prio_collision got=%0d exp=1", collision); end
    checks++; if (clampIdx !== 4'd2) begin errors++; $display("[TB] FAIL prio_index got=%0d exp=2", clampIdx); end
    for (int n = 0; n < 100; n++) begin
      applyStimulus(310, 310, 1, 0, 0);
      checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL prio_suppressed[%0d] got=%0d exp=0", n, collision); end
    end
    idle();
    checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL prio_suppressed_tail got=%0d exp=0", collision); end
    checks++; if (hitsInFrame !== 4'd1) begin errors++; $display("[TB] FAIL prio_hits got=%0d exp=1", hitsInFrame); end
    applyStimulus(310, 310, 1, 0, 1);
    checks++; if (hitsInFrame !== 4'd0) begin errors++; $display("[TB] FAIL prio_new_frame_hits got=%0d exp=0", hitsInFrame); end
    idle();
    checks++; if (collision !== 1'b1) begin errors++; $display("[TB] FAIL prio_rearmed got=%0d exp=1", collision); end
    checks++; if (clampIdx !== 4'd2) begin errors++; $display("[TB] FAIL prio_rearmed_index got=%0d exp=2", clampIdx); end
  endtask

  task automatic test_edges();
    clearObjs();
    placeObj(0, 70, 200);
    idle(1);
    applyStimulus(101, 210, 1, 0, 0);
    checks++; if (coronaDr !== 1'b1) begin errors++; $display("[TB] FAIL edge_101_corona got=%0d exp=1", coronaDr); end
    idle();
    checks++; if (collision !== 1'b1) begin errors++; $display("[TB] FAIL edge_101_collision got=%0d exp=1", collision); end
    idle(1);
    applyStimulus(102, 210, 1, 0, 0);
    checks++; if (coronaDr !== 1'b0) begin errors++; $display("[TB] FAIL edge_102_corona got=%0d exp=0", coronaDr); end
    idle();
    checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL edge_102_collision got=%0d exp=0", collision); end
    applyStimulus(80, 199, 1, 0, 0);
    checks++; if (coronaDr !== 1'b0) begin errors++; $display("[TB] FAIL edge_y_above got=%0d exp=0", coronaDr); end
    applyStimulus(80, 231, 1, 0, 0);
    checks++; if (coronaDr !== 1'b1) begin errors++; $display("[TB] FAIL edge_y_last got=%0d exp=1", coronaDr); end
  endtask

  task automatic test_signed();
    clearObjs();
    placeObj(3, -10, 400);
    idle(1);
    applyStimulus(5, 401, 1, 0, 0);
    checks++; if (coronaDr !== 1'b1) begin errors++; $display("[TB] FAIL signed_inside got=%0d exp=1", coronaDr); end
    idle();
    checks++; if (collision !== 1'b1) begin errors++; $display("[TB] FAIL signed_collision got=%0d exp=1", collision); end
    checks++; if (clampIdx !== 4'd3) begin errors++; $display("[TB] FAIL signed_index got=%0d exp=3", clampIdx); end
    idle(1);
    applyStimulus(22, 401, 1, 0, 0);
    checks++; if (coronaDr !== 1'b0) begin errors++; $display("[TB] FAIL signed_outside got=%0d exp=0", coronaDr); end
    idle();
    checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL signed_no_collision got=%0d exp=0", collision); end
  endtask

  task automatic test_other();
    clearObjs();
    idle(1);
    applyStimulus(500, 500, 0, 1, 0);
    idle();
    checks++; if (collision !== 1'b1) begin errors++; $display("[TB] FAIL other_collision got=%0d exp=1", collision); end
    checks++; if (clampIdx !== 4'd15) begin errors++; $display("[TB] FAIL other_index got=%0d exp=15", clampIdx); end
    placeObj(7, 600, 100);
    placeObj(8, 600, 100);
    idle(1);
    applyStimulus(610, 110, 1, 1, 0);
    idle();
    checks++; if (collision !== 1'b1) begin errors++; $display("[TB] FAIL other_corona_collision got=%0d exp=1", collision); end
    checks++; if (clampIdx !== 4'd7) begin errors++; $display("[TB] FAIL other_corona_index got=%0d exp=7", clampIdx); end
  endtask

  task automatic test_back_to_back();
    clearObjs();
    placeObj(0, 70, 200);
    idle(1);
    applyStimulus(80, 210, 1, 0, 0);
    idle(1);
    checks++; if (collision !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_pulse got=%0d exp=1", collision); end
    checks++; if (hitsInFrame !== 4'd1) begin errors++; $display("[TB] FAIL b2b_first_hits got=%0d exp=1", hitsInFrame); end
    for (int n = 0; n < 3; n++) begin
      idle();
      checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap[%0d] got=%0d exp=0", n, collision); end
    end
    applyStimulus(80, 210, 1, 0, 0);
    idle();
    checks++; if (collision !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_pulse got=%0d exp=1", collision); end
    checks++; if (hitsInFrame !== 4'd2) begin errors++; $display("[TB] FAIL b2b_second_hits got=%0d exp=2", hitsInFrame); end
  endtask

  task automatic test_midreset();
    clearObjs();
    placeObj(0, 70, 200);
    idle(1);
    applyStimulus(80, 210, 1, 1, 0);
    applyStimulus(81, 211, 1, 1, 0);
    #1 resetN = 1'b0;
    #1;
    checks++; if (coronaDr !== 1'b0) begin errors++; $display("[TB] FAIL midreset_corona got=%0d exp=0", coronaDr); end
    @(negedge clk);
    resetN = 1'b1;
    for (int n = 0; n < 2; n++) begin
      idle();
      checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flushed[%0d] got=%0d exp=0", n, collision); end
    end
    checks++; if (hitsInFrame !== 4'd0) begin errors++; $display("[TB] FAIL midreset_hits got=%0d exp=0", hitsInFrame); end
    checks++; if (clampIdx !== 4'd15) begin errors++; $display("[TB] FAIL midreset_index got=%0d exp=15", clampIdx); end
  endtask

  task automatic test_random();
    clearObjs();
    for (int k = 0; k < NumObj; k++) begin
      placeObj(k, int'($urandom_range(0, 240)) - 40, int'($urandom_range(0, 240)) - 40);
      drawReq[k] = 1'($urandom_range(0, 1));
    end
    for (int n = 0; n < 2000; n++) begin
      int k;
      checks++; if (coronaDr !== expCorona) begin errors++; $display("[TB] FAIL rand_corona[%0d] got=%0d exp=%0d", n, coronaDr, expCorona); end
      checks++; if (collision !== expColl) begin errors++; $display("[TB] FAIL rand_collision[%0d] got=%0d exp=%0d", n, collision, expColl); end
      if (expColl) begin
        checks++; if (clampIdx !== expIdx) begin errors++; $display("[TB] FAIL rand_index[%0d] got=%0d exp=%0d", n, clampIdx, expIdx); end
      end
      checks++; if (hitsInFrame !== expHits) begin errors++; $display("[TB] FAIL rand_hits[%0d] got=%0d exp=%0d", n, hitsInFrame, expHits); end
      if ($urandom_range(0, 7) == 0) begin
        k = int'($urandom_range(0, NumObj - 1));
        placeObj(k, int'($urandom_range(0, 240)) - 40, int'($urandom_range(0, 240)) - 40);
        drawReq[k] = 1'($urandom_range(0, 3) != 0);
      end
      applyStimulus(int'($urandom_range(0, 200)), int'($urandom_range(0, 200)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 24) == 0);
    end
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    pixelX = '0; pixelY = '0; clampDr = 1'b0; otherHit = 1'b0;
    clearObjs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_priority();
    test_edges();
    test_signed();
    test_other();
    test_back_to_back();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
